// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and helpers for the memory-side read arbiter and its
// round-robin arbitration core.
//   state_t    : arbiter FSM states (IDLE, BUSY)
//   req_id_t   : one-bit requester identifier
//   REQ_FETCH  : requester 0, instruction fetch
//   REQ_LOAD   : requester 1, data load
//   req_onehot : turns a requester id into a two-bit one-hot mask
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ_FETCH = 1'b0;
    localparam req_id_t REQ_LOAD  = 1'b1;

    // Per-requester response/error bits are laid out as a two-bit vector
    // indexed by requester id, so this mask is used wherever a single
    // requester's bit has to be raised or masked off.
    function automatic logic [1:0] req_onehot(input req_id_t id);
        return (id == REQ_LOAD) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// ---------------------------------------------------------------------------
// rr_arbiter_2
// Two-way round-robin arbiter: combinational winner selection plus the
// last_grant register. Shared by the read and write arbiters.
// Ports:
//   clock   in   system clock, rising edge
//   reset_n in   asynchronous active-low reset
//   req     in   request vector, bit n = requester n
//   update  in   commit the current winner as last_grant
//   winner  out  selected requester (meaningful only when valid=1)
//   valid   out  at least one request is present
// ---------------------------------------------------------------------------
module rr_arbiter_2
    import mem_arb_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic       winner,
    output logic       valid
);

    logic last_grant;

    // Winner selection. A lone requester always wins; on a tie the
    // requester that was not granted last time goes first, which gives
    // strict alternation under continuous contention.
    always_comb begin
        valid  = |req;
        winner = REQ_FETCH;
        case (req)
            2'b01:   winner = REQ_FETCH;
            2'b10:   winner = REQ_LOAD;
            2'b11:   winner = ~last_grant;
            default: winner = REQ_FETCH;
        endcase
    end

    // Priority history. Resetting to REQ_LOAD means the fetch port wins
    // the very first tie after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= REQ_LOAD;
        end else if (update && valid) begin
            last_grant <= winner;
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// ---------------------------------------------------------------------------
// mem_read_arbiter
// Shares one memory read port between instruction fetch (requester 0) and
// data load (requester 1). One transaction at a time, round-robin
// priority, back-to-back handoff with no bubble, and a per-transaction
// timeout that returns an error pulse.
// Ports:
//   clock, reset_n            clock and asynchronous active-low reset
//   rq_enable[1:0]            per-requester request, held until response
//   rq0/rq1_address, _index   request address / valid-bit index
//   rq_response[1:0]          one-cycle completion pulse per requester
//   rq_error[1:0]             qualifies rq_response: timeout abort
//   rq_data                   read data, valid with rq_response only
//   mem_address, mem_index    held stable towards memory while busy
//   mem_enable                memory request, held until mem_response
//   mem_data, mem_response    memory return data and completion pulse
// ---------------------------------------------------------------------------
module mem_read_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int DEPTH   = 65536,
    parameter  int TIMEOUT = 255,
    localparam int ADDR_W  = $clog2(DEPTH),
    localparam int IDX_W   = $clog2(WIDTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [1:0]        rq_enable,
    input  logic [ADDR_W-1:0] rq0_address,
    input  logic [ADDR_W-1:0] rq1_address,
    input  logic [IDX_W-1:0]  rq0_index,
    input  logic [IDX_W-1:0]  rq1_index,
    output logic [1:0]        rq_response,
    output logic [1:0]        rq_error,
    output logic [WIDTH-1:0]  rq_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic [IDX_W-1:0]  mem_index,
    output logic              mem_enable,
    input  logic [WIDTH-1:0]  mem_data,
    input  logic              mem_response
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state;
    state_t           state_next;
    logic             grant;
    logic [CNT_W-1:0] count;
    logic [1:0]       timeout_resp;
    logic [1:0]       arb_req;
    logic             arb_winner;
    logic             arb_valid;
    logic             completing;
    logic             timeout_hit;
    logic             grant_now;

    // Who may be arbitrated this cycle. In IDLE a requester whose timeout
    // pulse is on the outputs right now has not had a chance to drop its
    // enable yet, so it is masked. On completion only the other requester
    // may be handed the port directly; the finishing one is still holding
    // its enable for this cycle. A response that lands on the last timeout
    // cycle wins over the timeout.
    always_comb begin
        completing  = (state == BUSY) && mem_response;
        timeout_hit = (state == BUSY) && !mem_response && (TIMEOUT != 0) && (count == CNT_LAST);
        arb_req     = 2'b00;
        if (state == IDLE) begin
            arb_req = rq_enable & ~timeout_resp;
        end else if (completing) begin
            arb_req = rq_enable & ~req_onehot(grant);
        end
        grant_now = arb_valid && ((state == IDLE) || completing);
    end

    rr_arbiter_2 u_rr_arbiter (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (arb_req),
        .update  (grant_now),
        .winner  (arb_winner),
        .valid   (arb_valid)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic. BUSY stays BUSY across a completion when the
    // other requester is waiting, which is what keeps mem_enable high
    // through a handoff.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (completing) begin
                    state_next = arb_valid ? BUSY : IDLE;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Transaction datapath: latch the winner's address/index on every
    // grant and restart the timeout counter; otherwise count busy cycles,
    // saturating so the counter can never wrap back into range. The
    // timeout response is registered so it appears the cycle after expiry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            grant        <= REQ_FETCH;
            mem_address  <= '0;
            mem_index    <= '0;
            count        <= '0;
            timeout_resp <= 2'b00;
        end else begin
            timeout_resp <= timeout_hit ? req_onehot(grant) : 2'b00;
            if (grant_now) begin
                grant       <= arb_winner;
                mem_address <= (arb_winner == REQ_LOAD) ? rq1_address : rq0_address;
                mem_index   <= (arb_winner == REQ_LOAD) ? rq1_index : rq0_index;
                count       <= '0;
            end else if ((state == BUSY) && (count != CNT_MAX)) begin
                count <= count + 1'b1;
            end
        end
    end

    // FSM outputs. Normal completion is routed straight through in the
    // mem_response cycle; the timeout pulse comes from the register above.
    // The two can never overlap because a timeout always leaves BUSY.
    always_comb begin
        mem_enable  = (state == BUSY);
        rq_response = timeout_resp;
        rq_error    = timeout_resp;
        rq_data     = '0;
        if (completing) begin
            rq_response = req_onehot(grant);
            rq_data     = mem_data;
        end
    end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_read_arbiter
// Directed testbench for mem_read_arbiter built with TIMEOUT=4. Inputs are
// driven and outputs sampled around the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mem_read_arbiter;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 65536;
    localparam int TIMEOUT = 4;
    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int IDX_W   = $clog2(WIDTH);

    logic              clock = 1'b0;
    logic              reset_n;
    logic [1:0]        rq_enable;
    logic [ADDR_W-1:0] rq0_address;
    logic [ADDR_W-1:0] rq1_address;
    logic [IDX_W-1:0]  rq0_index;
    logic [IDX_W-1:0]  rq1_index;
    logic [1:0]        rq_response;
    logic [1:0]        rq_error;
    logic [WIDTH-1:0]  rq_data;
    logic [ADDR_W-1:0] mem_address;
    logic [IDX_W-1:0]  mem_index;
    logic              mem_enable;
    logic [WIDTH-1:0]  mem_data;
    logic              mem_response;

    int vectors     = 0;
    int miscompares = 0;

    mem_read_arbiter #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .rq_enable    (rq_enable),
        .rq0_address  (rq0_address),
        .rq1_address  (rq1_address),
        .rq0_index    (rq0_index),
        .rq1_index    (rq1_index),
        .rq_response  (rq_response),
        .rq_error     (rq_error),
        .rq_data      (rq_data),
        .mem_address  (mem_address),
        .mem_index    (mem_index),
        .mem_enable   (mem_enable),
        .mem_data     (mem_data),
        .mem_response (mem_response)
    );

    // Free-running 10-time-unit clock.
    always #5 clock = ~clock;

    // Single comparison point: counts every vector and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle's requester/memory inputs, then let combinational
    // outputs settle before anything is sampled.
    task automatic applyStimulus(input logic [1:0] en, input logic resp, input logic [31:0] data);
        rq_enable    = en;
        mem_response = resp;
        mem_data     = data;
        #1;
    endtask

    task automatic nextCycle;
        @(negedge clock);
    endtask

    // Checks the commonly observed outputs in one go.
    task automatic checkPorts(input string tag, input logic men, input logic [15:0] addr,
                              input logic [1:0] resp, input logic [1:0] err, input logic [31:0] data);
        checkOutput({tag, ".mem_enable"}, 64'(mem_enable), 64'(men));
        checkOutput({tag, ".mem_address"}, 64'(mem_address), 64'(addr));
        checkOutput({tag, ".rq_response"}, 64'(rq_response), 64'(resp));
        checkOutput({tag, ".rq_error"}, 64'(rq_error), 64'(err));
        checkOutput({tag, ".rq_data"}, 64'(rq_data), 64'(data));
    endtask

    task automatic doReset;
        reset_n = 1'b0;
        applyStimulus(2'b00, 1'b0, 32'h0);
        nextCycle;
        reset_n = 1'b1;
        nextCycle;
    endtask

    // One isolated transaction: request, 1-cycle issue latency, memory
    // answering 'latency' cycles after mem_enable rises, then release.
    // mem_data is kept non-zero while waiting so a leaky rq_data shows up.
    task automatic runSingle(input string tag, input logic req, input logic [15:0] addr,
                             input logic [4:0] idx, input int latency, input logic [31:0] data);
        logic [1:0] oh;
        oh = req ? 2'b10 : 2'b01;
        if (req) begin
            rq1_address = addr;
            rq1_index   = idx;
        end else begin
            rq0_address = addr;
            rq0_index   = idx;
        end
        applyStimulus(oh, 1'b0, data);
        checkOutput({tag, ".issue_latency"}, 64'(mem_enable), 64'd0);
        nextCycle;
        applyStimulus(oh, 1'b0, data);
        checkPorts({tag, ".issue"}, 1'b1, addr, 2'b00, 2'b00, 32'h0);
        checkOutput({tag, ".mem_index"}, 64'(mem_index), 64'(idx));
        for (int i = 1; i < latency; i++) begin
            nextCycle;
            applyStimulus(oh, 1'b0, data);
            checkPorts({tag, ".wait"}, 1'b1, addr, 2'b00, 2'b00, 32'h0);
        end
        nextCycle;
        applyStimulus(oh, 1'b1, data);
        checkPorts({tag, ".resp"}, 1'b1, addr, oh, 2'b00, data);
        nextCycle;
        applyStimulus(2'b00, 1'b0, 32'h0);
        checkPorts({tag, ".done"}, 1'b0, addr, 2'b00, 2'b00, 32'h0);
    endtask

    initial begin
        reset_n     = 1'b0;
        rq0_address = '0;
        rq1_address = '0;
        rq0_index   = '0;
        rq1_index   = '0;
        applyStimulus(2'b00, 1'b0, 32'h0);

        // Reset state.
        nextCycle;
        checkPorts("reset", 1'b0, 16'h0, 2'b00, 2'b00, 32'h0);
        checkOutput("reset.mem_index", 64'(mem_index), 64'd0);
        reset_n = 1'b1;
        nextCycle;

        // Single request from fetch; response lands on the last timeout
        // cycle (3 cycles after mem_enable with TIMEOUT=4) and must win.
        $display("[TB] single request / timeout coincidence");
        runSingle("single0", 1'b0, 16'h0010, 5'd3, 3, 32'hDEADBEEF);
        runSingle("single1", 1'b1, 16'h0020, 5'd7, 3, 32'hCAFEF00D);
        runSingle("fast1", 1'b1, 16'h0024, 5'd8, 1, 32'h0BADCAFE);

        // Simultaneous requests straight after reset: fetch first, then a
        // bubble-free handoff to load.
        $display("[TB] simultaneous requests");
        doReset;
        rq0_address = 16'h0004;
        rq0_index   = 5'd1;
        rq1_address = 16'h0008;
        rq1_index   = 5'd2;
        applyStimulus(2'b11, 1'b0, 32'h0);
        checkOutput("dual.issue_latency", 64'(mem_enable), 64'd0);
        nextCycle;
        applyStimulus(2'b11, 1'b1, 32'h11111111);
        checkPorts("dual.first", 1'b1, 16'h0004, 2'b01, 2'b00, 32'h11111111);
        nextCycle;
        applyStimulus(2'b10, 1'b0, 32'h0);
        checkPorts("dual.handoff", 1'b1, 16'h0008, 2'b00, 2'b00, 32'h0);
        checkOutput("dual.handoff.mem_index", 64'(mem_index), 64'd2);
        nextCycle;
        applyStimulus(2'b10, 1'b1, 32'h22222222);
        checkPorts("dual.second", 1'b1, 16'h0008, 2'b10, 2'b00, 32'h22222222);
        nextCycle;
        applyStimulus(2'b00, 1'b0, 32'h0);
        checkOutput("dual.idle", 64'(mem_enable), 64'd0);

        // Continuous contention: both always requesting, memory answering
        // in the first busy cycle. Grants must alternate 0,1,0,1...
        $display("[TB] continuous contention");
        rq0_address = 16'h0100;
        rq1_address = 16'h0200;
        applyStimulus(2'b11, 1'b0, 32'h0);
        nextCycle;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(2'b11, 1'b1, 32'hA0000000 + 32'(i));
            checkPorts($sformatf("rr%0d", i), 1'b1, (i % 2 == 0) ? 16'h0100 : 16'h0200,
                       (i % 2 == 0) ? 2'b01 : 2'b10, 2'b00, 32'hA0000000 + 32'(i));
            nextCycle;
        end
        applyStimulus(2'b01, 1'b1, 32'hA0000008);
        checkPorts("rr8", 1'b1, 16'h0100, 2'b01, 2'b00, 32'hA0000008);
        nextCycle;
        applyStimulus(2'b00, 1'b0, 32'h0);
        checkOutput("rr.idle", 64'(mem_enable), 64'd0);

        // Timeout: load requests, memory never answers. Error response
        // exactly TIMEOUT cycles after mem_enable rose, and no re-grant
        // while the requester is still seeing its error pulse.
        $display("[TB] timeout");
        rq1_address = 16'h0030;
        rq1_index   = 5'd9;
        applyStimulus(2'b10, 1'b0, 32'h0);
        nextCycle;
        applyStimulus(2'b10, 1'b0, 32'h0);
        checkPorts("to.issue", 1'b1, 16'h0030, 2'b00, 2'b00, 32'h0);
        for (int i = 1; i < TIMEOUT; i++) begin
            nextCycle;
            applyStimulus(2'b10, 1'b0, 32'h0);
            checkPorts($sformatf("to.wait%0d", i), 1'b1, 16'h0030, 2'b00, 2'b00, 32'h0);
        end
        nextCycle;
        applyStimulus(2'b10, 1'b0, 32'h0);
        checkPorts("to.expire", 1'b0, 16'h0030, 2'b10, 2'b10, 32'h0);
        nextCycle;
        applyStimulus(2'b00, 1'b0, 32'h0);
        checkPorts("to.after", 1'b0, 16'h0030, 2'b00, 2'b00, 32'h0);

        // Reset in the middle of a busy transaction, then a stray late
        // memory response that must be ignored.
        $display("[TB] reset mid-transaction");
        rq0_address = 16'h0040;
        rq0_index   = 5'd4;
        applyStimulus(2'b01, 1'b0, 32'h0);
        nextCycle;
        applyStimulus(2'b01, 1'b0, 32'h0);
        checkPorts("rst.busy", 1'b1, 16'h0040, 2'b00, 2'b00, 32'h0);
        nextCycle;
        reset_n = 1'b0;
        applyStimulus(2'b01, 1'b1, 32'h55555555);
        checkPorts("rst.async", 1'b0, 16'h0, 2'b00, 2'b00, 32'h0);
        checkOutput("rst.async.mem_index", 64'(mem_index), 64'd0);
        nextCycle;
        reset_n = 1'b1;
        applyStimulus(2'b00, 1'b0, 32'h0);
        nextCycle;
        applyStimulus(2'b00, 1'b1, 32'h55555555);
        checkPorts("rst.stray", 1'b0, 16'h0, 2'b00, 2'b00, 32'h0);
        nextCycle;
        applyStimulus(2'b00, 1'b0, 32'h0);
        checkPorts("rst.quiet", 1'b0, 16'h0, 2'b00, 2'b00, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
